// File: rtl/game_pkg.sv
// Shared definitions for the game session sequencer and the LCD controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds the display state codes, the matching FSM enum and the user ID constants.
package game_pkg;

  // Display state codes, shared with the LCD controller.
  localparam logic [7:0] ST_AUTH       = 8'h00;
  localparam logic [7:0] ST_GRANT      = 8'h01;
  localparam logic [7:0] ST_DENY       = 8'h02;
  localparam logic [7:0] ST_PLAY       = 8'h10;
  localparam logic [7:0] ST_WIN_BEGIN  = 8'h20;
  localparam logic [7:0] ST_WIN_END    = 8'h21;
  localparam logic [7:0] ST_LOSE_BEGIN = 8'h30;
  localparam logic [7:0] ST_LOSE_END   = 8'h31;

  // Known user IDs.
  localparam logic [3:0] USER_ID_0 = 4'b1100;
  localparam logic [3:0] USER_ID_1 = 4'b0011;
  localparam logic [3:0] USER_ID_2 = 4'b1101;
  localparam logic [3:0] USER_ID_3 = 4'b0100;

  // FSM encoding is the display code itself, so the state register drives the LCD directly.
  typedef enum logic [7:0] {
    S_AUTH       = ST_AUTH,
    S_GRANT      = ST_GRANT,
    S_DENY       = ST_DENY,
    S_PLAY       = ST_PLAY,
    S_WIN_BEGIN  = ST_WIN_BEGIN,
    S_WIN_END    = ST_WIN_END,
    S_LOSE_BEGIN = ST_LOSE_BEGIN,
    S_LOSE_END   = ST_LOSE_END
  } state_t;

endpackage

// File: rtl/game_state_sequencer_hold_timer.sv
// Hold timer: counts cycles spent in a timed screen and flags the last one.
// Latency: done is combinational from the count register (high on the limit-1 cycle).
// Backpressure: none; clear has priority over counting.
//
// Ports: clk, reset (sync, active-low), clear (restart at 0), sel_long (use LIMIT_LONG
// instead of LIMIT_SHORT), done (count == selected limit - 1).
module hold_timer #(
  parameter int unsigned W           = 3,
  parameter int unsigned LIMIT_SHORT = 8,
  parameter int unsigned LIMIT_LONG  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sel_long,
  output logic done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    done = sel_long ? (count == W'(LIMIT_LONG - 1)) : (count == W'(LIMIT_SHORT - 1));
  end

endmodule

// File: rtl/game_state_sequencer.sv
// Game session sequencer: drives the LCD display state code and authenticated user ID.
// Latency: one cycle from a sampled event to the new state/user/game_active outputs.
// Backpressure: none; events not valid in the current state are dropped.
//
// Ports: clk, reset (sync, active-low), auth_valid/auth_ok/auth_id (credential pulse),
// game_win/game_lose (game result pulses), ack (dismiss end screen),
// state (8-bit display code), user (latched user ID), game_active (high in PLAY).
// Optional build macro: LOCKOUT_EN (consecutive-denial lockout with a longer DENY screen).
module game_state_sequencer
  import game_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 100000000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       auth_valid,
  input  logic       auth_ok,
  input  logic [3:0] auth_id,
  input  logic       game_win,
  input  logic       game_lose,
  input  logic       ack,
  output logic [7:0] state,
  output logic [3:0] user,
  output logic       game_active
);

`ifdef LOCKOUT_EN
  localparam int unsigned MAX_HOLD = (LOCKOUT_CYCLES > HOLD_CYCLES) ? LOCKOUT_CYCLES : HOLD_CYCLES;
  localparam int unsigned FW       = $clog2(MAX_FAILS + 1);
`else
  localparam int unsigned MAX_HOLD = HOLD_CYCLES;
`endif
  localparam int unsigned TW = $clog2(MAX_HOLD);

  state_t state_q;
  logic   timed;
  logic   done;
  logic   sel_long;

  // Non-timed states keep the timer pinned at 0, and a timed state clears it on its
  // final cycle, so every timed state is entered with a zero count.
  always_comb begin
    timed = (state_q == S_GRANT) || (state_q == S_DENY) ||
            (state_q == S_WIN_BEGIN) || (state_q == S_LOSE_BEGIN);
  end

`ifdef LOCKOUT_EN
  logic [FW-1:0] fail_cnt;
  logic          lockout_q;

  // lockout_q marks the DENY visit triggered by the MAX_FAILS-th consecutive denial.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fail_cnt  <= '0;
      lockout_q <= 1'b0;
    end else begin
      if (state_q == S_AUTH && auth_valid) begin
        if (auth_ok) begin
          fail_cnt <= '0;
        end else if (fail_cnt >= FW'(MAX_FAILS - 1)) begin
          fail_cnt  <= FW'(MAX_FAILS);
          lockout_q <= 1'b1;
        end else begin
          fail_cnt <= fail_cnt + 1'b1;
        end
      end else if (state_q == S_DENY && done && lockout_q) begin
        fail_cnt  <= '0;
        lockout_q <= 1'b0;
      end
    end
  end

  always_comb begin
    sel_long = (state_q == S_DENY) && lockout_q;
  end
`else
  always_comb begin
    sel_long = 1'b0;
  end
`endif

  hold_timer #(
    .W           (TW),
    .LIMIT_SHORT (HOLD_CYCLES),
`ifdef LOCKOUT_EN
    .LIMIT_LONG  (LOCKOUT_CYCLES)
`else
    .LIMIT_LONG  (HOLD_CYCLES)
`endif
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (!timed || done),
    .sel_long (sel_long),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_AUTH;
      user        <= 4'b0000;
      game_active <= 1'b0;
    end else begin
      case (state_q)
        S_AUTH: begin
          if (auth_valid) begin
            if (auth_ok) begin
              state_q <= S_GRANT;
              user    <= auth_id;
            end else begin
              state_q <= S_DENY;
            end
          end
        end
        S_GRANT: begin
          if (done) begin
            state_q     <= S_PLAY;
            game_active <= 1'b1;
          end
        end
        S_DENY: begin
          if (done) state_q <= S_AUTH;
        end
        S_PLAY: begin
          // Lose wins a same-cycle tie.
          if (game_lose) begin
            state_q     <= S_LOSE_BEGIN;
            game_active <= 1'b0;
          end else if (game_win) begin
            state_q     <= S_WIN_BEGIN;
            game_active <= 1'b0;
          end
        end
        S_WIN_BEGIN: begin
          if (done) state_q <= S_WIN_END;
        end
        S_LOSE_BEGIN: begin
          if (done) state_q <= S_LOSE_END;
        end
        S_WIN_END, S_LOSE_END: begin
          if (ack) begin
            state_q <= S_AUTH;
            user    <= 4'b0000;
          end
        end
        default: begin
          state_q     <= S_AUTH;
          user        <= 4'b0000;
          game_active <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule
